// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter (start bit, 8 data bits LSB first, stop bit).
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   tx_in    - byte to send, captured when a frame starts
//   tx_en    - level-sensitive transmit request, ignored while busy
//   tx       - registered serial output, idles high
//   tx_busy  - registered, high for exactly 10 bit periods per frame
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_in,
    input  logic       tx_en,
    output logic       tx,
    output logic       tx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_done;

    // Last cycle of the current bit period
    assign bit_done = (cnt_q == CNT_MAX);

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; tx/busy are computed one edge ahead so they change
    // on the same edge as the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                bit_d  = '0;
                if (tx_en) begin
                    shift_d = tx_in;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with a short bit period (16 clocks).
module tb_uart_tx;

    localparam int unsigned CLK_FREQ  = 160;
    localparam int unsigned BAUD_RATE = 10;
    localparam int          CPB       = 16;

    logic       clk;
    logic       reset;
    logic [7:0] tx_in;
    logic       tx_en;
    logic       tx;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tx_in  (tx_in),
        .tx_en  (tx_en),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for busy, then samples tx at every mid-bit and counts busy cycles.
    // Returns at the first falling-edge sample showing busy low.
    task automatic capture_frame(output logic [9:0] bits, output int busy_len,
                                 output int wait_cyc, output bit timeout);
        bits     = '0;
        busy_len = 0;
        wait_cyc = 0;
        timeout  = 1'b0;
        while (tx_busy !== 1'b1 && wait_cyc < 4 * CPB) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (tx_busy !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        while (tx_busy === 1'b1 && busy_len < 12 * CPB) begin
            if ((busy_len % CPB) == CPB / 2 && (busy_len / CPB) < 10)
                bits[busy_len / CPB] = tx;
            busy_len++;
            @(negedge clk);
        end
        if (tx_busy === 1'b1) timeout = 1'b1;
    endtask

    task automatic test_reset();
        bit quiet;
        reset = 1'b0;
        tx_en = 1'b0;
        tx_in = 8'h00;
        #100;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy);
        end
        quiet = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_idle_quiet: activity seen with tx_en=0, expected none");
        end
    endtask

    task automatic test_single_byte(input logic [7:0] b);
        logic [9:0] bits;
        logic [7:0] exp;
        int         len, wt;
        bit         to;
        tx_in = b;
        tx_en = 1'b1;
        exp_q.push_back(b);
        fork
            capture_frame(bits, len, wt, to);
            begin
                repeat (CPB / 2) @(negedge clk);
                tx_en = 1'b0;
            end
        join
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL byte_%h_timeout: frame did not start or end in bound", b);
        end
        checks++;
        if (wt != 1) begin
            errors++;
            $display("FAIL byte_%h_latency: busy after %0d cycles, expected 1", b, wt);
        end
        checks++;
        if (bits !== {1'b1, exp, 1'b0}) begin
            errors++;
            $display("FAIL byte_%h_bits: got %b expected %b", b, bits, {1'b1, exp, 1'b0});
        end
        checks++;
        if (len != 10 * CPB) begin
            errors++;
            $display("FAIL byte_%h_busy_len: got %0d expected %0d", b, len, 10 * CPB);
        end
    endtask

    task automatic test_mid_frame_change();
        logic [9:0] bits;
        logic [7:0] exp;
        int         len, wt;
        bit         to, quiet;
        tx_in = 8'h0F;
        tx_en = 1'b1;
        exp_q.push_back(8'h0F);
        fork
            capture_frame(bits, len, wt, to);
            begin
                @(negedge clk);
                tx_en = 1'b0;
                repeat (3 * CPB + 2) @(negedge clk);
                tx_in = 8'hF0;
                tx_en = 1'b1;
                @(negedge clk);
                tx_en = 1'b0;
            end
        join
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL midchange_timeout: frame did not complete in bound");
        end
        checks++;
        if (bits !== {1'b1, exp, 1'b0}) begin
            errors++;
            $display("FAIL midchange_bits: got %b expected %b", bits, {1'b1, exp, 1'b0});
        end
        checks++;
        if (len != 10 * CPB) begin
            errors++;
            $display("FAIL midchange_busy_len: got %0d expected %0d", len, 10 * CPB);
        end
        quiet = 1'b1;
        for (int i = 0; i < 2 * CPB; i++) begin
            if (tx_busy !== 1'b0 || tx !== 1'b1) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midchange_single_frame: extra frame seen, expected exactly one");
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        logic [7:0] exp;
        int         len, wt;
        bit         to, quiet;
        tx_in = 8'h81;
        tx_en = 1'b1;
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h81);
        capture_frame(bits, len, wt, to);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (to || bits !== {1'b1, exp, 1'b0} || len != 10 * CPB) begin
            errors++;
            $display("FAIL b2b_frame1: bits=%b len=%0d to=%0b expected bits=%b len=%0d",
                     bits, len, to, {1'b1, exp, 1'b0}, 10 * CPB);
        end
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap_idle: tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy);
        end
        fork
            capture_frame(bits, len, wt, to);
            begin
                repeat (CPB / 2) @(negedge clk);
                tx_en = 1'b0;
            end
        join
        checks++;
        if (wt != 1) begin
            errors++;
            $display("FAIL b2b_gap_len: idle gap %0d cycles, expected 1", wt);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (to || bits !== {1'b1, exp, 1'b0} || len != 10 * CPB) begin
            errors++;
            $display("FAIL b2b_frame2: bits=%b len=%0d to=%0b expected bits=%b len=%0d",
                     bits, len, to, {1'b1, exp, 1'b0}, 10 * CPB);
        end
        quiet = 1'b1;
        for (int i = 0; i < 2 * CPB; i++) begin
            if (tx_busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL b2b_stop: frame after tx_en dropped, expected none");
        end
    endtask

    task automatic test_reset_mid_frame();
        tx_in = 8'hC3;
        tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        checks++;
        if (tx_busy !== 1'b1 || tx !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre: tx=%b busy=%b expected tx=0 busy=1 (data bit 4 of C3)",
                     tx, tx_busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_single_byte(8'h3C);
    endtask

    initial begin
        test_reset();
        test_single_byte(8'h55);
        repeat (3) @(negedge clk);
        test_single_byte(8'hAA);
        repeat (3) @(negedge clk);
        test_mid_frame_change();
        test_back_to_back();
        test_reset_mid_frame();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Accepts a byte through a level-sensitive enable and reports activity on a busy flag.
- Sits between a host-side byte source and the serial TX pin.
- Bit timing is derived from a fixed integer clock divider.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in baud. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division; 5208 at defaults). CLKS_PER_BIT must be >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- tx_in  input  8  byte to transmit; sampled only when a frame starts.
- tx_en  input  1  transmit request; level-sensitive.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; while it is asserted the block holds state IDLE, tx=1, tx_busy=0, and counters and shift register are 0.
- Both outputs are registered. There are no combinational paths from inputs to outputs.
- Internal state: state (IDLE/START/DATA/STOP), baud counter of width $clog2(CLKS_PER_BIT), bit index (3 bits), 8-bit shift register.
- IDLE:
  - tx=1, tx_busy=0.
  - On a rising edge with tx_en=1, latch tx_in into the shift register and go to START.
  - On that same edge, set tx=0 and tx_busy=1. Zero cycles of latency between request and start-bit onset; both outputs change on the same edge.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift_reg[bit index] for CLKS_PER_BIT cycles per bit, LSB first.
  - After bit 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_busy stays 1 for the whole stop bit.
- Frame end: at the end of STOP, return to IDLE and clear tx_busy. Total frame = exactly 10*CLKS_PER_BIT cycles of tx_busy=1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 at each bit boundary. No drift; bit edges fall at multiples of CLKS_PER_BIT from the start edge.
- tx_en and tx_in are ignored while tx_busy=1. Changing tx_in mid-frame does not alter the frame.
- tx_en held high across the end of a frame: the block returns to IDLE for one cycle (tx=1, tx_busy=0). A new frame starts on the next edge if tx_en is still 1, so there is a minimum of one idle cycle between frames.
- A short tx_en pulse (even one cycle) while IDLE starts a full frame. Holding tx_en for less than one frame yields exactly one frame.
- Reset asserted mid-frame: the frame aborts immediately (asynchronously) with tx=1 and tx_busy=0. After release the block is IDLE and responds to the next tx_en.
- Unreachable state encodings recover to IDLE with tx=1.

Test Plan:
- Reset: hold reset=0 for 100 ns, release. Expect tx=1 and tx_busy=0, with no activity while tx_en=0.
- Byte 0x55: pulse tx_en=1 with tx_in=0x55, hold for half a bit. Expect tx_busy to rise on the first edge. Sample at mid-bit: start=0; data bits 1,0,1,0,1,0,1,0; stop=1. tx_busy falls exactly 10*5208 cycles after rising.
- Byte 0xAA: after the 0x55 frame completes, send 0xAA. Expect mid-bit samples 0, then 0,1,0,1,0,1,0,1, then 1; tx_busy=1 for 52080 cycles.
- Mid-frame input change: start frame 0x0F, change tx_in to 0xF0 and pulse tx_en during bit 2. Expect the transmitted data to still be 0x0F and exactly one frame.
- Back-to-back: hold tx_en=1 continuously with tx_in=0x81. Expect consecutive frames separated by exactly one cycle with tx=1 and tx_busy=0.
- Reset mid-frame: assert reset=0 during data bit 4. Expect tx=1 and tx_busy=0 immediately. After release, a new 0x3C frame transmits correctly.
